// File: rtl/vga_stream_unpack.sv
// vga_stream_unpack
//   Parametrised VGA timing generator with a word-to-pixel unpacker. It pulls
//   packed frame-buffer words from a show-ahead (FWFT) line FIFO and drives
//   registered hsync/vsync/de and RGB565 to the VGA pins.
//
// Ports
//   vga_clk      in   pixel clock
//   vga_rst_n    in   asynchronous active-low reset
//   enable       in   display enable, sampled only at the frame origin
//   gray_mode    in   1: top 8 bits of each pixel are luma; 0: pixel is RGB565
//   rd_data      in   FIFO head word, valid whenever rd_empty=0
//   rd_empty     in   FIFO empty
//   rd_en        out  FIFO pop (combinational)
//   vga_hsync    out  horizontal sync (polarity set by SYNC_POL)
//   vga_vsync    out  vertical sync (polarity set by SYNC_POL)
//   vga_de       out  data enable
//   vga_r/g/b    out  5/6/5-bit colour, zero whenever vga_de=0
//   frame_start  out  one-clock pulse for the h=0, v=0 counter state
//   underflow    out  sticky: a word slot in this frame found the FIFO empty
module vga_stream_unpack #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int WORD_W   = 32,
  parameter int PIX_W    = 16,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              vga_clk,
  input  logic              vga_rst_n,
  input  logic              enable,
  input  logic              gray_mode,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              rd_empty,
  output logic              rd_en,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_de,
  output logic [4:0]        vga_r,
  output logic [5:0]        vga_g,
  output logic [4:0]        vga_b,
  output logic              frame_start,
  output logic              underflow
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int PPW     = WORD_W / PIX_W;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int H_A0    = H_SYNC + H_BP;
  localparam int H_A1    = H_A0 + H_ACTIVE;
  localparam int V_A0    = V_SYNC + V_BP;
  localparam int V_A1    = V_A0 + V_ACTIVE;

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic              frame_en_q, frame_en_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              blank_q, blank_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic [4:0]        r_q, r_d;
  logic [5:0]        g_q, g_d;
  logic [4:0]        b_q, b_d;
  logic              frame_start_q, frame_start_d;
  logic              underflow_q, underflow_d;

  logic              h_wrap, v_wrap, at_origin, active, slot_start;
  logic [PIX_W-1:0]  pix;
  logic              pix_black;
  logic [15:0]       p16;
  logic [5:0]        luma_hi;

  always_comb begin
    h_wrap     = (int'(h_cnt_q) == H_TOTAL - 1);
    v_wrap     = (int'(v_cnt_q) == V_TOTAL - 1);
    at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
    active     = (int'(h_cnt_q) >= H_A0) && (int'(h_cnt_q) < H_A1) &&
                 (int'(v_cnt_q) >= V_A0) && (int'(v_cnt_q) < V_A1);
    // First pixel of a word slot: the only cycle a pop can happen.
    slot_start = frame_en_q && active && (sub_q == '0);
  end

  assign rd_en = slot_start & ~rd_empty;

  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end

    sub_d = '0;
    if (active) begin
      sub_d = (int'(sub_q) == PPW - 1) ? '0 : sub_q + 1'b1;
    end

    frame_en_d = at_origin ? enable : frame_en_q;
    word_d     = rd_en ? rd_data : word_q;
    // Remembers that the current slot underflowed so its later pixels stay black.
    blank_d    = slot_start ? rd_empty : blank_q;

    // Slot's first pixel comes straight off the FIFO head; the rest from the held word.
    if (sub_q == '0) begin
      pix       = rd_data[WORD_W-1 -: PIX_W];
      pix_black = rd_empty;
    end else begin
      pix       = PIX_W'(word_q >> ((PPW - 1 - int'(sub_q)) * PIX_W));
      pix_black = blank_q;
    end
    p16     = 16'(pix);
    luma_hi = pix[PIX_W-1 -: 6];

    de_d = active && frame_en_q;
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (de_d && !pix_black) begin
      if (gray_mode) begin
        r_d = luma_hi[5:1];
        g_d = luma_hi;
        b_d = luma_hi[5:1];
      end else begin
        r_d = p16[15:11];
        g_d = p16[10:5];
        b_d = p16[4:0];
      end
    end

    hsync_d       = (int'(h_cnt_q) < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (int'(v_cnt_q) < V_SYNC) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = at_origin;

    // Set wins over the frame-origin clear.
    underflow_d = underflow_q;
    if (at_origin) underflow_d = 1'b0;
    if (slot_start && rd_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      sub_q         <= '0;
      frame_en_q    <= 1'b0;
      word_q        <= '0;
      blank_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      sub_q         <= sub_d;
      frame_en_q    <= frame_en_d;
      word_q        <= word_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_stream_unpack.sv
// Bench for vga_stream_unpack on a small 28x7 raster:
//   H = 4 sync / 4 bp / 16 active / 4 fp, V = 1 / 1 / 4 / 1, 32-bit words of two 16-bit pixels.
module tb_vga_stream_unpack;

  typedef struct {
    logic [31:0] word;
    logic        gray;
    logic [4:0]  r0;
    logic [5:0]  g0;
    logic [4:0]  b0;
    logic [4:0]  r1;
    logic [5:0]  g1;
    logic [4:0]  b1;
  } vec_t;

  logic        vga_clk = 1'b0;
  logic        vga_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        gray_mode = 1'b0;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_en;
  logic        vga_hsync, vga_vsync, vga_de;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;
  logic        vga_frame_start, vga_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: show-ahead, main process writes, pop process reads.
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_total = 0;
  logic        hold_empty = 1'b0;
  logic        pop_req = 1'b0;

  assign rd_data  = mem[rd_ptr % 64];
  assign rd_empty = hold_empty || (wr_ptr == rd_ptr);

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) pop_req <= rd_en;

  initial begin
    forever begin
      @(posedge vga_clk);
      #1;
      if (pop_req && (wr_ptr != rd_ptr)) begin
        rd_ptr++;
        pop_total++;
      end
    end
  end

  vga_stream_unpack #(
    .H_SYNC(4), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .WORD_W(32), .PIX_W(16), .SYNC_POL(1'b0)
  ) dut (
    .vga_clk    (vga_clk),
    .vga_rst_n  (vga_rst_n),
    .enable     (enable),
    .gray_mode  (gray_mode),
    .rd_data    (rd_data),
    .rd_empty   (rd_empty),
    .rd_en      (rd_en),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_de     (vga_de),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .frame_start(vga_frame_start),
    .underflow  (vga_underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Entered at the negedge where frame_start is seen; returns at the next one.
  task automatic run_frame(input vec_t v, input int exp_pops, input int exp_de,
                           input bit hole, input bit drop_en, input bit raise_en,
                           input string tag);
    int cyc = 0, de_n = 0, hs_lo = 0, vs_lo = 0, lines = 0;
    int bad_pop = 0, stray_rgb = 0, pop0, x, er, eg, eb;
    bit prev_de = 0, ufl_last = 0, blk;
    gray_mode  = v.gray;
    hold_empty = 1'b0;
    wr_ptr     = rd_ptr;
    for (int i = 0; i < 32; i++) push(v.word);
    pop0 = pop_total;
    if (raise_en) enable = 1'b1;
    while (cyc < 400) begin
      @(negedge vga_clk);
      cyc++;
      if (!vga_hsync) hs_lo++;
      if (!vga_vsync) vs_lo++;
      if (hold_empty && rd_en) bad_pop++;
      if (vga_de && !prev_de) lines++;
      prev_de = vga_de;
      if (vga_de) begin
        x   = de_n % 16;
        blk = hole && (de_n >= 4) && (de_n <= 9);
        if (blk) begin
          er = 0; eg = 0; eb = 0;
        end else if (x % 2 == 0) begin
          er = v.r0; eg = v.g0; eb = v.b0;
        end else begin
          er = v.r1; eg = v.g1; eb = v.b1;
        end
        chk({tag, " pix r"}, vga_r, er);
        chk({tag, " pix g"}, vga_g, eg);
        chk({tag, " pix b"}, vga_b, eb);
        de_n++;
        if (hole && de_n == 4) begin
          hold_empty = 1'b1;
          #1;
          chk({tag, " rd_en while empty"}, rd_en, 0);
        end
        if (hole && de_n == 10) hold_empty = 1'b0;
        if (drop_en && de_n == 10) enable = 1'b0;
      end else if ({vga_r, vga_g, vga_b} != 16'h0) begin
        stray_rgb++;
      end
      if (vga_frame_start) break;
      ufl_last = vga_underflow;
    end
    chk({tag, " frame period"}, cyc, 196);
    chk({tag, " underflow at frame_start"}, vga_underflow, 0);
    chk({tag, " underflow end of frame"}, ufl_last, hole);
    chk({tag, " pops"}, pop_total - pop0, exp_pops);
    chk({tag, " de clocks"}, de_n, exp_de);
    chk({tag, " de lines"}, lines, exp_de / 16);
    chk({tag, " hsync low clocks"}, hs_lo, 28);
    chk({tag, " vsync low clocks"}, vs_lo, 28);
    chk({tag, " pops while empty"}, bad_pop, 0);
    chk({tag, " rgb outside de"}, stray_rgb, 0);
  endtask

  vec_t vecs [7];
  vec_t white;

  initial begin
    int k;
    vecs[0] = '{32'h1234ABCD, 1'b0, 5'h02, 6'h11, 5'h14, 5'h15, 6'h1E, 5'h0D};
    vecs[1] = '{32'h8000FF00, 1'b1, 5'h10, 6'h20, 5'h10, 5'h1F, 6'h3F, 5'h1F};
    vecs[2] = '{32'hFFFF0000, 1'b0, 5'h1F, 6'h3F, 5'h1F, 5'h00, 6'h00, 5'h00};
    vecs[3] = '{32'hF80007E0, 1'b0, 5'h1F, 6'h00, 5'h00, 5'h00, 6'h3F, 5'h00};
    vecs[4] = '{32'h001F0821, 1'b0, 5'h00, 6'h00, 5'h1F, 5'h01, 6'h01, 5'h01};
    vecs[5] = '{32'h12345678, 1'b1, 5'h02, 6'h04, 5'h02, 5'h0A, 6'h15, 5'h0A};
    vecs[6] = '{32'h3C11C3EE, 1'b1, 5'h07, 6'h0F, 5'h07, 5'h18, 6'h30, 5'h18};
    white   = '{32'hFFFFFFFF, 1'b0, 5'h1F, 6'h3F, 5'h1F, 5'h1F, 6'h3F, 5'h1F};

    // Reset state
    repeat (3) @(negedge vga_clk);
    chk("reset hsync", vga_hsync, 1);
    chk("reset vsync", vga_vsync, 1);
    chk("reset de", vga_de, 0);
    chk("reset rgb", {vga_r, vga_g, vga_b}, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset frame_start", vga_frame_start, 0);
    chk("reset underflow", vga_underflow, 0);

    vga_rst_n = 1'b1;
    @(negedge vga_clk);
    chk("first frame_start", vga_frame_start, 1);

    // Blank first frame (enable low at its origin, raised mid-frame)
    run_frame(vecs[0], 0, 0, 1'b0, 1'b0, 1'b1, "blank_after_reset");

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], 32, 64, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Three empty fetch slots on the first active line
    run_frame(white, 29, 64, 1'b1, 1'b0, 1'b0, "underflow");

    // Enable drops mid-frame, frame completes; next frame blank; then resumes
    run_frame(vecs[0], 32, 64, 1'b0, 1'b1, 1'b0, "enable_drop");
    run_frame(vecs[1], 0, 0, 1'b0, 1'b0, 1'b1, "disabled_frame");
    run_frame(vecs[2], 32, 64, 1'b0, 1'b0, 1'b0, "resumed");

    // Asynchronous reset in the middle of an active line
    wr_ptr = rd_ptr;
    for (int i = 0; i < 32; i++) push(vecs[0].word);
    k = 0;
    while (!vga_de && k < 400) begin
      @(negedge vga_clk);
      k++;
    end
    chk("reached de before reset", vga_de, 1);
    repeat (2) @(negedge vga_clk);
    #2;
    vga_rst_n = 1'b0;
    #1;
    chk("midreset hsync", vga_hsync, 1);
    chk("midreset vsync", vga_vsync, 1);
    chk("midreset de", vga_de, 0);
    chk("midreset rgb", {vga_r, vga_g, vga_b}, 0);
    chk("midreset rd_en", rd_en, 0);
    chk("midreset frame_start", vga_frame_start, 0);
    repeat (2) @(negedge vga_clk);
    vga_rst_n = 1'b1;
    #1;
    chk("release frame_start before clock", vga_frame_start, 0);
    @(negedge vga_clk);
    chk("release frame_start after one clock", vga_frame_start, 1);
    chk("release hsync active", vga_hsync, 0);
    chk("release vsync active", vga_vsync, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
